// File: rtl/hex_display_scanner.sv
// Scan controller for a common-anode multi-digit 7-segment display.
// Walks through the digits of a double-buffered hex value, one slot per
// PRESCALE cycles, with a dark guard interval at the start of every slot.
module hex_display_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
  output logic [3:0]            digit,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   pending;
  logic [4*DIGITS-1:0]   shown;
  logic                  slotEnd;
  logic                  frameEnd;
  logic [DIGITS:0]       zeroFromHere;
  logic [DIGITS-1:0]     blanked;

  assign slotEnd  = (cnt == CW'(PRESCALE - 1));
  assign frameEnd = slotEnd && (idx == IW'(DIGITS - 1));

  // Prescaler, slot index, double buffer and frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      shown      <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (slotEnd) begin
        cnt <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (load) pending <= value;
      // A load landing on the boundary itself goes straight to the screen.
      if (frameEnd) shown <= load ? value : pending;
      frame_tick <= frameEnd;
    end
  end

  // zeroFromHere[i]: shown nibbles i..DIGITS-1 are all zero.
  assign zeroFromHere[DIGITS] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : gDigit
    assign zeroFromHere[g] = zeroFromHere[g+1] && (shown[4*g +: 4] == 4'h0);
    if (g == 0) begin : gFirst
      // Digit 0 always shows, so a zero value reads as a single "0".
      assign blanked[g] = blank_mask[g];
    end else begin : gUpper
      assign blanked[g] = blank_mask[g] | (lz_en & zeroFromHere[g]);
    end
  end

  // Nibble select for the current slot; shown even while dark.
  always_comb begin
    digit = 4'h0;
    for (int i = 0; i < DIGITS; i++)
      if (idx == IW'(i)) digit = shown[4*i +: 4];
  end

  // At most one anode low: the current slot, outside guard, if not blanked.
  always_comb begin
    anode = '1;
    if (cnt >= CW'(GUARD)) begin
      for (int i = 0; i < DIGITS; i++)
        if (idx == IW'(i) && !blanked[i]) anode[i] = 1'b0;
    end
  end

endmodule
